// File: rtl/mul_exu.sv
// mul_exu: iterative shift-add multiplier execution unit with RVS issue and CDB broadcast.
// Define MUL_EXU_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module mul_exu #(
    parameter int TAG_W     = 4,
    parameter int OPC_W     = 4,
    parameter int ROB_PTR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exu_req,
    output logic                 exu_rdy,
    input  logic [TAG_W-1:0]     exu_tag,
    input  logic [OPC_W-1:0]     exu_opc,
    input  logic [31:0]          exu_src1,
    input  logic [31:0]          exu_src2,
    input  logic [ROB_PTR_W-1:0] exu_inst_id,
    output logic                 cdb_req,
    input  logic                 cdb_gnt,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [31:0]          cdb_wdata,
    output logic [ROB_PTR_W-1:0] cdb_inst_id
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef MUL_EXU_RADIX4_EN
    localparam logic [4:0] CNT_END = 5'd15;
`else
    localparam logic [4:0] CNT_END = 5'd31;
`endif
    logic [1:0]           state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [63:0]          acc_q, acc_d;
    logic [63:0]          mcd_q, mcd_d;
    logic [31:0]          mplr_q, mplr_d;
    logic                 neg_q, neg_d;
    logic                 hi_q, hi_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [ROB_PTR_W-1:0] id_q, id_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 sgn1, sgn2;
    logic [63:0]          step, prod;
    logic                 opc_unused;
    assign opc_unused  = ^exu_opc;
    assign exu_rdy     = (state_q == IDLE);
    assign cdb_req     = (state_q == DONE);
    assign cdb_tag     = tag_q;
    assign cdb_wdata   = wdata_q;
    assign cdb_inst_id = id_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcd_d   = mcd_q;
        mplr_d  = mplr_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        tag_d   = tag_q;
        id_d    = id_q;
        wdata_d = wdata_q;
        sgn1    = (exu_opc[1:0] != 2'd3) && exu_src1[31];
        sgn2    = !exu_opc[1] && exu_src2[31];
`ifdef MUL_EXU_RADIX4_EN
        step    = acc_q + (mplr_q[0] ? mcd_q : 64'd0) + (mplr_q[1] ? {mcd_q[62:0], 1'b0} : 64'd0);
`else
        step    = acc_q + (mplr_q[0] ? mcd_q : 64'd0);
`endif
        prod    = neg_q ? -step : step;
        if (state_q == IDLE && exu_req) begin
            state_d = BUSY;
            cnt_d   = 5'd0;
            acc_d   = 64'd0;
            // magnitude of 0x80000000 is exactly representable as 32-bit unsigned
            mcd_d   = {32'd0, (sgn1 ? -exu_src1 : exu_src1)};
            mplr_d  = sgn2 ? -exu_src2 : exu_src2;
            neg_d   = sgn1 ^ sgn2;
            hi_d    = (exu_opc[1:0] != 2'd0);
            tag_d   = exu_tag;
            id_d    = exu_inst_id;
        end else if (state_q == BUSY) begin
            acc_d = step;
            cnt_d = cnt_q + 5'd1;
`ifdef MUL_EXU_RADIX4_EN
            mcd_d  = {mcd_q[61:0], 2'b00};
            mplr_d = {2'b00, mplr_q[31:2]};
`else
            mcd_d  = {mcd_q[62:0], 1'b0};
            mplr_d = {1'b0, mplr_q[31:1]};
`endif
            if (cnt_q == CNT_END) begin
                state_d = DONE;
                wdata_d = hi_q ? prod[63:32] : prod[31:0];
            end
        end else if (state_q == DONE && cdb_gnt) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            mcd_q   <= 64'd0;
            mplr_q  <= 32'd0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            tag_q   <= '0;
            id_q    <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcd_q   <= mcd_d;
            mplr_q  <= mplr_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            tag_q   <= tag_d;
            id_q    <= id_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mul_exu.sv
// tb_mul_exu: scoreboard bench for mul_exu; expected results queued at issue, checked at CDB grant.
module tb_mul_exu;
`ifdef MUL_EXU_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif
    logic        clk = 0;
    logic        rst = 1;
    logic        exu_req = 0;
    logic        exu_rdy;
    logic [3:0]  exu_tag = 0;
    logic [3:0]  exu_opc = 0;
    logic [31:0] exu_src1 = 0;
    logic [31:0] exu_src2 = 0;
    logic [3:0]  exu_inst_id = 0;
    logic        cdb_req;
    logic        cdb_gnt = 1;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_wdata;
    logic [3:0]  cdb_inst_id;

    mul_exu #(.TAG_W(4), .OPC_W(4), .ROB_PTR_W(4)) dut (
        .clk(clk), .rst(rst), .exu_req(exu_req), .exu_rdy(exu_rdy),
        .exu_tag(exu_tag), .exu_opc(exu_opc), .exu_src1(exu_src1), .exu_src2(exu_src2),
        .exu_inst_id(exu_inst_id), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
        .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata), .cdb_inst_id(cdb_inst_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [3:0]  id;
        logic [31:0] wd;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          grant_cyc = 0;
    bit          in_done = 0;
    bit          was_gnt = 0;
    logic [3:0]  h_tag, h_id;
    logic [31:0] h_wd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, yb, p;
        xa = (opc[1:0] != 2'd3) ? {{32{a[31]}}, a} : {32'd0, a};
        yb = (opc[1:0] <= 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * yb;
        return (opc[1:0] == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [3:0] id, input logic [31:0] exp);
        exp_t e;
        int   n;
        @(negedge clk);
        exu_opc = opc; exu_src1 = a; exu_src2 = b; exu_tag = tag; exu_inst_id = id;
        exu_req = 1;
        n = 0;
        while (!exu_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("issue_timeout", 1, 0);
        e.tag = tag; e.id = id; e.wd = exp; e.acc = cyc;
        last_acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 exu_req = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_done = 0;
            was_gnt = 0;
        end else begin
            if (was_gnt) chk("req_drop", 64'(cdb_req), 0);
            was_gnt = 0;
            if (cdb_req) begin
                if (!in_done) begin
                    in_done = 1;
                    h_tag = cdb_tag; h_id = cdb_inst_id; h_wd = cdb_wdata;
                    if (sb.size() == 0) chk("spurious_req", 1, 0);
                    else begin
                        chk("latency", 64'(cyc - sb[0].acc), 64'(LAT));
                        chk("tag", 64'(cdb_tag), 64'(sb[0].tag));
                        chk("inst_id", 64'(cdb_inst_id), 64'(sb[0].id));
                        chk("wdata", 64'(cdb_wdata), 64'(sb[0].wd));
                    end
                end else begin
                    chk("hold_tag", 64'(cdb_tag), 64'(h_tag));
                    chk("hold_id", 64'(cdb_inst_id), 64'(h_id));
                    chk("hold_wdata", 64'(cdb_wdata), 64'(h_wd));
                    chk("hold_rdy", 64'(exu_rdy), 0);
                end
                if (cdb_gnt) begin
                    was_gnt = 1;
                    in_done = 0;
                    grant_cyc = cyc;
                    if (sb.size() != 0) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        #2;
        chk("rst_rdy", 64'(exu_rdy), 1);
        chk("rst_req", 64'(cdb_req), 0);
        chk("rst_wdata", 64'(cdb_wdata), 0);
        chk("rst_tag", 64'(cdb_tag), 0);
        chk("rst_id", 64'(cdb_inst_id), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        issue(4'd0, 32'd3, 32'd5, 4'd2, 4'd7, 32'h0000000F);
        issue(4'd1, 32'h80000000, 32'h80000000, 4'd3, 4'd1, 32'h40000000);
        issue(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 4'd2, 32'h00000000);
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 4'd3, 32'hFFFFFFFF);
        issue(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, 4'd4, 32'hFFFFFFFE);
        issue(4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 4'd5, 32'h00000001);
        issue(4'd7, 32'hFFFFFFFF, 32'd2, 4'd9, 4'd6, 32'h00000001);
        // withheld grant while the next op waits on exu_req
        @(negedge clk);
        while (!exu_rdy) @(negedge clk);
        cdb_gnt = 0;
        issue(4'd1, 32'h12345678, 32'h9ABCDEF0, 4'd10, 4'd8, model(4'd1, 32'h12345678, 32'h9ABCDEF0));
        fork
            issue(4'd0, 32'd100, 32'd200, 4'd11, 4'd9, 32'd20000);
            begin
                n = 0;
                while (!cdb_req && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 100) chk("gnt_wait_timeout", 1, 0);
                repeat (5) @(posedge clk);
                #1 cdb_gnt = 1;
            end
        join
        chk("accept_after_gnt", 64'(last_acc), 64'(grant_cyc + 1));
        // reset in the middle of a BUSY op
        @(negedge clk);
        while (!exu_rdy) @(negedge clk);
        issue(4'd0, 32'd9, 32'd9, 4'd12, 4'd10, 32'd81);
        repeat (9) @(posedge clk);
        #1 rst = 1;
        sb.delete();
        #2;
        chk("mid_rst_rdy", 64'(exu_rdy), 1);
        chk("mid_rst_req", 64'(cdb_req), 0);
        chk("mid_rst_wdata", 64'(cdb_wdata), 0);
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);
        chk("post_rst_rdy", 64'(exu_rdy), 1);
        issue(4'd0, 32'd2, 32'd2, 4'd13, 4'd11, 32'd4);
        for (int i = 0; i < 6; i++) begin
            logic [3:0]  o;
            logic [31:0] a, b;
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (i == 0) a = 32'h80000000;
            if (i == 1) b = 32'h80000000;
            issue(o, a, b, 4'(i), 4'(15 - i), model(o, a, b));
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mul_exu.md
MUL_EXU -- requirements
Module: mul_exu

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of RVS/CDB tag.
REQ-002 SHALL have parameter OPC_W, default 4, width of opcode; only opc[1:0] decoded.
REQ-003 SHALL have parameter ROB_PTR_W, default 4, width of ROB instruction id.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port exu_req  input  1  RVS issue valid.
REQ-007 SHALL have port exu_rdy  output  1  unit can accept issue.
REQ-008 SHALL have port exu_tag  input  TAG_W  RVS entry tag of issued op.
REQ-009 SHALL have port exu_opc  input  OPC_W  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
REQ-010 SHALL have ports exu_src1, exu_src2  input  32  operands rs1, rs2.
REQ-011 SHALL have port exu_inst_id  input  ROB_PTR_W  ROB id of issued op.
REQ-012 SHALL have port cdb_req  output  1  result valid, requesting CDB.
REQ-013 SHALL have port cdb_gnt  input  1  CDB arbiter grant.
REQ-014 SHALL have ports cdb_tag  output  TAG_W, cdb_wdata  output  32, cdb_inst_id  output  ROB_PTR_W  broadcast payload.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, DONE; exu_rdy = (state==IDLE), no other term.
REQ-016 Issue accepted when exu_req && exu_rdy at a rising edge; tag, opc, inst_id, operands latched; IDLE->BUSY.
REQ-017 Inputs SHALL be ignored whenever exu_rdy is low; only one op in flight.
REQ-018 At accept: operand signedness per opc (MUL/MULH: both signed; MULHSU: src1 signed, src2 unsigned; MULHU: both unsigned); magnitudes latched, result sign = XOR of effective signs.
REQ-019 BUSY: unsigned shift-add, 1 multiplier bit per cycle into 64-bit accumulator; 5-bit counter from 0, BUSY->DONE when counter reaches 31.
REQ-020 On BUSY->DONE: 64-bit product negated (two's complement) if result sign set; cdb_wdata = product[31:0] for MUL, product[63:32] otherwise.
REQ-021 Accept in cycle 0: BUSY cycles 1..32, cdb_req first high in cycle 33.
REQ-022 DONE: cdb_req held high, cdb_tag/cdb_wdata/cdb_inst_id stable until cdb_gnt sampled high.
REQ-023 cdb_gnt high in DONE: DONE->IDLE at that edge, cdb_req low next cycle; new issue acceptable only in following IDLE cycle (no same-cycle turnaround).
REQ-024 cdb_gnt SHALL be ignored outside DONE.
REQ-025 opc[OPC_W-1:2] SHALL not affect result.
REQ-026 Operand 0x80000000 signed: magnitude 0x80000000 handled as 33-bit-safe unsigned; no overflow in 64-bit product.
REQ-027 All outputs SHALL be driven from registers or the state register only.

Reset
REQ-028 rst high SHALL immediately force state IDLE, counter 0, accumulator 0, cdb_req 0, cdb_tag/cdb_wdata/cdb_inst_id 0, exu_rdy 1 after release.
REQ-029 rst during BUSY or DONE SHALL abandon the op with no CDB broadcast.

Configuration
REQ-030 Macro MUL_EXU_RADIX4_EN defined: 2 multiplier bits per cycle, counter ends at 15, cdb_req first high in cycle 17 after accept in cycle 0.
REQ-031 MUL_EXU_RADIX4_EN undefined: radix-2, 32 BUSY cycles per REQ-019/REQ-021; results identical in both builds.

Verification
REQ-032 MUL 3 x 5, tag 2, id 7, gnt tied high -> cdb_req cycle 33 (17 radix-4), wdata 0x0000000F, tag 2, inst_id 7, one cycle.
REQ-033 MULH 0x80000000 x 0x80000000 -> wdata 0x40000000; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
REQ-034 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; MUL same -> 0x00000001.
REQ-035 gnt withheld 5 cycles in DONE, exu_req held high with new op -> cdb_req/payload stable 5 cycles, exu_rdy low, new op accepted first IDLE cycle after grant.
REQ-036 rst pulsed at BUSY cycle 10 -> cdb_req never asserted for that op, exu_rdy high after release, next MUL 2 x 2 -> wdata 4.
REQ-037 exu_req with opc 0x7 (bits[1:0]=3), 0xFFFFFFFF x 2 -> wdata 0x00000001 (MULHU).
